// File: rtl/sys_cmd_pkg.sv
// ============================================================================
// Module      : sys_cmd_pkg
// Description : Shared definitions for the command host: FSM state encoding,
//               command-type encodings, frame opcodes and per-type frame and
//               response lengths.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sys_cmd_pkg;

    // Controller state encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Command type encoding as presented on cmd_type
    typedef enum logic [1:0] {
        CMD_RF_WR   = 2'd0,
        CMD_RF_RD   = 2'd1,
        CMD_ALU_OP  = 2'd2,
        CMD_ALU_NOP = 2'd3
    } cmd_type_t;

    // Leading opcode byte of each frame
    localparam logic [7:0] c_OP_RF_WR   = 8'hAA;
    localparam logic [7:0] c_OP_RF_RD   = 8'hBB;
    localparam logic [7:0] c_OP_ALU_OP  = 8'hCC;
    localparam logic [7:0] c_OP_ALU_NOP = 8'hDD;

    // Number of bytes transmitted for a command, opcode included
    function automatic logic [2:0] frame_len(input cmd_type_t t);
        case (t)
            CMD_RF_WR:   frame_len = 3'd3;
            CMD_RF_RD:   frame_len = 3'd2;
            CMD_ALU_OP:  frame_len = 3'd4;
            default:     frame_len = 3'd2;
        endcase
    endfunction

    // Number of bytes expected back from the target for a command
    function automatic logic [1:0] rsp_len(input cmd_type_t t);
        case (t)
            CMD_RF_WR:   rsp_len = 2'd0;
            CMD_RF_RD:   rsp_len = 2'd1;
            default:     rsp_len = 2'd2;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/sys_cmd_timer.sv
// ============================================================================
// Module      : sys_cmd_timer
// Description : Saturating response-wait counter. Clear has priority over
//               enable; o_expired is high once LIMIT enabled cycles have
//               elapsed since the last clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sys_cmd_timer #(
    parameter int LIMIT = 65535
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int c_CW = $clog2(LIMIT + 1);
    localparam logic [c_CW-1:0] c_LIMIT = c_CW'(LIMIT);

    logic [c_CW-1:0] r_cnt;
    logic            w_expired;

    assign w_expired = (r_cnt >= c_LIMIT);
    assign o_expired = w_expired;

    // Count enabled cycles, holding at the limit until cleared
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable && !w_expired) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/sys_cmd_host.sv
// ============================================================================
// Module      : sys_cmd_host
// Description : Serialises register-file / ALU commands into UART byte
//               frames, then collects the 0/1/2-byte response and presents
//               it as a single-cycle strobe.
//               Optional feature macro: SYS_CMD_HOST_TIMEOUT_EN adds a
//               response-wait timeout (TIMEOUT_CYCLES) via sys_cmd_timer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sys_cmd_host
    import sys_cmd_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_SIZE      = 4,
    parameter int FUNC_WIDTH     = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_type,
    input  logic [ADDR_SIZE-1:0]    cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_a,
    input  logic [DATA_WIDTH-1:0]   cmd_b,
    input  logic [FUNC_WIDTH-1:0]   cmd_func,
    output logic [DATA_WIDTH-1:0]   tx_byte,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    input  logic [DATA_WIDTH-1:0]   rx_byte,
    input  logic                    rx_valid,
    output logic [2*DATA_WIDTH-1:0] rsp_data,
    output logic                    rsp_valid,
    output logic                    rsp_timeout
);

    state_t                  r_state;
    state_t                  w_state_nxt;
    cmd_type_t               r_type;
    logic [ADDR_SIZE-1:0]    r_addr;
    logic [DATA_WIDTH-1:0]   r_a;
    logic [DATA_WIDTH-1:0]   r_b;
    logic [FUNC_WIDTH-1:0]   r_func;
    logic [2:0]              r_tx_idx;
    logic [1:0]              r_rx_cnt;
    logic [2*DATA_WIDTH-1:0] r_rsp_data;

    logic                    w_accept;
    logic                    w_tx_hs;
    logic                    w_tx_last;
    logic                    w_rx_hs;
    logic                    w_rx_last;
    logic                    w_expired;
    logic [DATA_WIDTH-1:0]   w_frame_byte;

    assign w_accept  = cmd_valid && (r_state == ST_IDLE);
    assign w_tx_hs   = (r_state == ST_SEND) && tx_ready;
    assign w_tx_last = w_tx_hs && (r_tx_idx == (frame_len(r_type) - 3'd1));
    // Bytes arriving outside WAIT are stray and simply dropped
    assign w_rx_hs   = (r_state == ST_WAIT) && rx_valid;
    assign w_rx_last = w_rx_hs && (r_rx_cnt == (rsp_len(r_type) - 2'd1));

`ifdef SYS_CMD_HOST_TIMEOUT_EN
    logic r_timeout;
    logic w_tmr_clear;

    // Restart on every WAIT entry (counter idles clear elsewhere) and on each rx byte
    assign w_tmr_clear = (r_state != ST_WAIT) || rx_valid;

    sys_cmd_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timer (
        .clk       (CLK),
        .rst_n     (RST),
        .i_clear   (w_tmr_clear),
        .i_enable  (r_state == ST_WAIT),
        .o_expired (w_expired)
    );

    // Latch the timeout flag for the response that ends a stalled WAIT
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_timeout <= 1'b0;
        end else if (w_accept) begin
            r_timeout <= 1'b0;
        end else if ((r_state == ST_WAIT) && !w_rx_last && w_expired) begin
            r_timeout <= 1'b1;
        end
    end

    assign rsp_timeout = (r_state == ST_DONE) && r_timeout;
`else
    assign w_expired   = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    // Select the frame byte addressed by the transmit index
    always_comb begin
        w_frame_byte = '0;
        case (r_type)
            CMD_RF_WR: begin
                case (r_tx_idx)
                    3'd0:    w_frame_byte = DATA_WIDTH'(c_OP_RF_WR);
                    3'd1:    w_frame_byte = DATA_WIDTH'(r_addr);
                    default: w_frame_byte = r_a;
                endcase
            end
            CMD_RF_RD: begin
                case (r_tx_idx)
                    3'd0:    w_frame_byte = DATA_WIDTH'(c_OP_RF_RD);
                    default: w_frame_byte = DATA_WIDTH'(r_addr);
                endcase
            end
            CMD_ALU_OP: begin
                case (r_tx_idx)
                    3'd0:    w_frame_byte = DATA_WIDTH'(c_OP_ALU_OP);
                    3'd1:    w_frame_byte = r_a;
                    3'd2:    w_frame_byte = r_b;
                    default: w_frame_byte = DATA_WIDTH'(r_func);
                endcase
            end
            default: begin
                case (r_tx_idx)
                    3'd0:    w_frame_byte = DATA_WIDTH'(c_OP_ALU_NOP);
                    default: w_frame_byte = DATA_WIDTH'(r_func);
                endcase
            end
        endcase
    end

    // State register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (w_tx_last) begin
                    w_state_nxt = (r_type == CMD_RF_WR) ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (w_rx_last || w_expired) begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Command capture, frame index and response assembly
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_type     <= CMD_RF_WR;
            r_addr     <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_func     <= '0;
            r_tx_idx   <= '0;
            r_rx_cnt   <= '0;
            r_rsp_data <= '0;
        end else if (w_accept) begin
            r_type     <= cmd_type_t'(cmd_type);
            r_addr     <= cmd_addr;
            r_a        <= cmd_a;
            r_b        <= cmd_b;
            r_func     <= cmd_func;
            r_tx_idx   <= '0;
            r_rx_cnt   <= '0;
            r_rsp_data <= '0;
        end else begin
            if (w_tx_hs) begin
                r_tx_idx <= r_tx_idx + 3'd1;
            end
            // Response bytes arrive LSB first
            if (w_rx_hs) begin
                r_rx_cnt <= r_rx_cnt + 2'd1;
                if (r_rx_cnt == 2'd0) begin
                    r_rsp_data[DATA_WIDTH-1:0] <= rx_byte;
                end else begin
                    r_rsp_data[2*DATA_WIDTH-1:DATA_WIDTH] <= rx_byte;
                end
            end
        end
    end

    assign cmd_ready = (r_state == ST_IDLE);
    assign tx_valid  = (r_state == ST_SEND);
    assign tx_byte   = (r_state == ST_SEND) ? w_frame_byte : '0;
    assign rsp_valid = (r_state == ST_DONE);
    assign rsp_data  = r_rsp_data;

endmodule

`default_nettype wire
